// File: rtl/tank_lever_mapper.sv
//------------------------------------------------------------------------------
// tank_lever_mapper
//
// Per player channel: debounces a 4-way stick plus a second {up,down} stick,
// maps the debounced state to dual-tread levers (A = left tread, B = right
// tread, each fw/bk) and shapes coin requests into fixed-width pulses with a
// minimum gap and a one-deep pending buffer.
//
// Ports:
//   clk_sys       in   system clock, rising edge
//   Reset_n       in   synchronous active-low reset
//   deb_cycles_i  in   stability cycles required before a stick change is
//                      accepted; 0 bypasses the debouncer
//   coin_pulse_i  in   coin high time in cycles (0 behaves as 1)
//   coin_gap_i    in   minimum low time after each pulse (0 behaves as 1)
//   mode_i        in   per channel: 0 = 8-way translate, 1 = raw dual-stick
//   dir_i         in   per channel {up,down,left,right}, active high
//   stickb_i      in   per channel second stick {up,down}, raw mode only
//   coin_i        in   per channel coin request level, active high
//   lever_o       out  per channel {A_fw,A_bk,B_fw,B_bk}, registered
//   coin_o        out  per channel shaped coin pulse, registered
//   coin_drop_o   out  per channel 1-cycle strobe on a discarded coin edge
//------------------------------------------------------------------------------
module tank_lever_mapper #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEB_W  = 8,
    parameter int unsigned COIN_W = 16
) (
    input  logic                  clk_sys,
    input  logic                  Reset_n,
    input  logic [DEB_W-1:0]      deb_cycles_i,
    input  logic [COIN_W-1:0]     coin_pulse_i,
    input  logic [COIN_W-1:0]     coin_gap_i,
    input  logic [NUM_CH-1:0]     mode_i,
    input  logic [4*NUM_CH-1:0]   dir_i,
    input  logic [2*NUM_CH-1:0]   stickb_i,
    input  logic [NUM_CH-1:0]     coin_i,
    output logic [4*NUM_CH-1:0]   lever_o,
    output logic [NUM_CH-1:0]     coin_o,
    output logic [NUM_CH-1:0]     coin_drop_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } coin_state_t;

    // Reload values: a programmed 0 behaves as 1, so the counter loads N-1.
    logic [COIN_W-1:0] w_pulse_ld;
    logic [COIN_W-1:0] w_gap_ld;
    logic              w_deb_bypass;

    assign w_pulse_ld   = (coin_pulse_i == '0) ? '0 : coin_pulse_i - COIN_W'(1);
    assign w_gap_ld     = (coin_gap_i   == '0) ? '0 : coin_gap_i   - COIN_W'(1);
    assign w_deb_bypass = (deb_cycles_i == '0);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

        //----------------------------------------------------------------------
        // Debounce on {up,down,left,right,b_up,b_down}
        //----------------------------------------------------------------------
        logic [5:0]       w_raw;
        logic [5:0]       r_samp;
        logic [5:0]       r_stable;
        logic [5:0]       w_deb;
        logic [DEB_W-1:0] r_cnt;
        logic [DEB_W:0]   w_cnt_inc;

        assign w_raw     = {dir_i[4*ch +: 4], stickb_i[2*ch +: 2]};
        assign w_cnt_inc = {1'b0, r_cnt} + (DEB_W+1)'(1);
        // In bypass the decoder reads samp directly, giving 2-edge latency.
        assign w_deb     = w_deb_bypass ? r_samp : r_stable;

        always_ff @(posedge clk_sys) begin
            if (!Reset_n) begin
                r_samp   <= '0;
                r_stable <= '0;
                r_cnt    <= '0;
            end else begin
                r_samp <= w_raw;
                if (w_deb_bypass) begin
                    r_stable <= r_samp;
                    r_cnt    <= '0;
                end else if (r_samp == r_stable) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc >= {1'b0, deb_cycles_i}) begin
                    r_stable <= r_samp;
                    r_cnt    <= '0;
                end else if (w_raw != r_samp) begin
                    // samp is about to change: the new value starts from 0
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc[DEB_W-1:0];
                end
            end
        end

        //----------------------------------------------------------------------
        // Lever decode
        //----------------------------------------------------------------------
        logic [3:0] w_lever;
        logic [3:0] r_lever;

        always_comb begin
            w_lever = '0;
            if (mode_i[ch]) begin
                w_lever = {w_deb[5] & ~w_deb[4], w_deb[4] & ~w_deb[5],
                           w_deb[1] & ~w_deb[0], w_deb[0] & ~w_deb[1]};
            end else begin
                case (w_deb[5:2])
                    4'b1000: w_lever = 4'b1010;
                    4'b1010: w_lever = 4'b0010;
                    4'b1001: w_lever = 4'b1000;
                    4'b0001: w_lever = 4'b1001;
                    4'b0101: w_lever = 4'b0100;
                    4'b0100: w_lever = 4'b0101;
                    4'b0110: w_lever = 4'b0001;
                    4'b0010: w_lever = 4'b0110;
                    default: w_lever = 4'b0000;
                endcase
            end
        end

        always_ff @(posedge clk_sys) begin
            if (!Reset_n) begin
                r_lever <= '0;
            end else begin
                r_lever <= w_lever;
            end
        end

        assign lever_o[4*ch +: 4] = r_lever;

        //----------------------------------------------------------------------
        // Coin pulse shaper
        //----------------------------------------------------------------------
        coin_state_t       r_state, w_state_nx;
        logic [COIN_W-1:0] r_ccnt, w_ccnt_nx;
        logic              r_coin, w_coin_nx;
        logic              r_pend, w_pend_nx;
        logic              r_drop, w_drop_nx;
        logic              r_prev;
        logic              r_arm;
        logic              w_rise;
        logic              w_absorb;

        // r_arm blocks a level already high across reset from counting as a
        // new edge; it arms once coin_i has been seen low.
        assign w_rise = coin_i[ch] & ~r_prev & r_arm;

        always_ff @(posedge clk_sys) begin
            if (!Reset_n) begin
                r_state <= S_IDLE;
                r_ccnt  <= '0;
                r_coin  <= 1'b0;
                r_pend  <= 1'b0;
                r_drop  <= 1'b0;
                r_prev  <= 1'b0;
                r_arm   <= ~coin_i[ch];
            end else begin
                r_state <= w_state_nx;
                r_ccnt  <= w_ccnt_nx;
                r_coin  <= w_coin_nx;
                r_pend  <= w_pend_nx;
                r_drop  <= w_drop_nx;
                r_prev  <= coin_i[ch];
                if (!coin_i[ch]) begin
                    r_arm <= 1'b1;
                end
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_ccnt_nx  = r_ccnt;
            w_coin_nx  = r_coin;
            w_pend_nx  = r_pend;
            w_drop_nx  = 1'b0;
            w_absorb   = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        w_state_nx = S_PULSE;
                        w_ccnt_nx  = w_pulse_ld;
                        w_coin_nx  = 1'b1;
                    end
                end
                S_PULSE: begin
                    w_absorb = w_rise;
                    if (r_ccnt != '0) begin
                        w_ccnt_nx = r_ccnt - COIN_W'(1);
                    end else begin
                        w_state_nx = S_GAP;
                        w_ccnt_nx  = w_gap_ld;
                        w_coin_nx  = 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_ccnt != '0) begin
                        w_ccnt_nx = r_ccnt - COIN_W'(1);
                        w_absorb  = w_rise;
                    end else if (r_pend) begin
                        // pending coin is served; a same-cycle edge re-queues
                        w_state_nx = S_PULSE;
                        w_ccnt_nx  = w_pulse_ld;
                        w_coin_nx  = 1'b1;
                        w_pend_nx  = 1'b0;
                        w_absorb   = w_rise;
                    end else if (w_rise) begin
                        w_state_nx = S_PULSE;
                        w_ccnt_nx  = w_pulse_ld;
                        w_coin_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_coin_nx  = 1'b0;
                end
            endcase
            if (w_absorb) begin
                if (w_pend_nx) begin
                    w_drop_nx = 1'b1;
                end else begin
                    w_pend_nx = 1'b1;
                end
            end
        end

        assign coin_o[ch]      = r_coin;
        assign coin_drop_o[ch] = r_drop;
    end

endmodule

// File: tb/tb_tank_lever_mapper.sv
//------------------------------------------------------------------------------
// Self-checking bench for tank_lever_mapper (2 channels).
// Lever expectations come from the direction table / raw-mode formulas and the
// documented latency; coin expectations come from a cycle-count model that
// tracks remaining high/low cycles and a pending flag.
//------------------------------------------------------------------------------
module tb_tank_lever_mapper;

    localparam int NUM_CH = 2;
    localparam int DEB_W  = 8;
    localparam int COIN_W = 16;

    localparam logic [3:0] TK [8] = '{4'b1000, 4'b1010, 4'b1001, 4'b0001,
                                     4'b0101, 4'b0100, 4'b0110, 4'b0010};
    localparam logic [3:0] TV [8] = '{4'b1010, 4'b0010, 4'b1000, 4'b1001,
                                     4'b0100, 4'b0101, 4'b0001, 4'b0110};

    logic                  clk_sys = 1'b0;
    logic                  Reset_n;
    logic [DEB_W-1:0]      deb_cycles_i;
    logic [COIN_W-1:0]     coin_pulse_i;
    logic [COIN_W-1:0]     coin_gap_i;
    logic [NUM_CH-1:0]     mode_i;
    logic [4*NUM_CH-1:0]   dir_i;
    logic [2*NUM_CH-1:0]   stickb_i;
    logic [NUM_CH-1:0]     coin_i;
    logic [4*NUM_CH-1:0]   lever_o;
    logic [NUM_CH-1:0]     coin_o;
    logic [NUM_CH-1:0]     coin_drop_o;

    tank_lever_mapper #(
        .NUM_CH (NUM_CH),
        .DEB_W  (DEB_W),
        .COIN_W (COIN_W)
    ) dut (
        .clk_sys      (clk_sys),
        .Reset_n      (Reset_n),
        .deb_cycles_i (deb_cycles_i),
        .coin_pulse_i (coin_pulse_i),
        .coin_gap_i   (coin_gap_i),
        .mode_i       (mode_i),
        .dir_i        (dir_i),
        .stickb_i     (stickb_i),
        .coin_i       (coin_i),
        .lever_o      (lever_o),
        .coin_o       (coin_o),
        .coin_drop_o  (coin_drop_o)
    );

    always #5 clk_sys = ~clk_sys;

    int n_assert = 0;
    int n_fail   = 0;

    // coin model state, per channel
    int m_hi   [NUM_CH];
    int m_lo   [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_prev [NUM_CH];
    bit m_arm  [NUM_CH];
    bit m_out  [NUM_CH];
    bit m_drop [NUM_CH];

    int hi_cnt0;
    int drop_cnt0;

    logic [5:0] vec     [NUM_CH];
    logic [5:0] old_vec [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] f_lever(input logic [5:0] v, input logic m);
        if (m) return {v[5] & ~v[4], v[4] & ~v[5], v[1] & ~v[0], v[0] & ~v[1]};
        for (int i = 0; i < 8; i++) begin
            if (v[5:2] == TK[i]) return TV[i];
        end
        return 4'b0000;
    endfunction

    function automatic logic [7:0] exp_lever(input logic [5:0] v0, input logic [5:0] v1,
                                             input logic [1:0] m);
        return {f_lever(v1, m[1]), f_lever(v0, m[0])};
    endfunction

    // Advance the coin model by one clock edge using the inputs present now.
    task automatic model_step();
        int P;
        int G;
        bit rise;
        bit absorb;
        P = (coin_pulse_i == 0) ? 1 : int'(coin_pulse_i);
        G = (coin_gap_i == 0) ? 1 : int'(coin_gap_i);
        for (int c = 0; c < NUM_CH; c++) begin
            if (!Reset_n) begin
                m_hi[c] = 0; m_lo[c] = 0; m_pend[c] = 0; m_prev[c] = 0;
                m_arm[c] = !coin_i[c]; m_out[c] = 0; m_drop[c] = 0;
            end else begin
                rise   = coin_i[c] && !m_prev[c] && m_arm[c];
                m_prev[c] = coin_i[c];
                if (!coin_i[c]) m_arm[c] = 1;
                m_drop[c] = 0;
                absorb = 0;
                if (m_hi[c] > 0) begin
                    absorb = rise;
                    if (m_hi[c] == 1) begin
                        m_hi[c] = 0;
                        m_lo[c] = G;
                    end else begin
                        m_hi[c]--;
                    end
                end else if (m_lo[c] > 0) begin
                    if (m_lo[c] > 1) begin
                        m_lo[c]--;
                        absorb = rise;
                    end else begin
                        m_lo[c] = 0;
                        if (m_pend[c]) begin
                            m_pend[c] = 0;
                            m_hi[c] = P;
                            absorb = rise;
                        end else if (rise) begin
                            m_hi[c] = P;
                        end
                    end
                end else if (rise) begin
                    m_hi[c] = P;
                end
                if (absorb) begin
                    if (m_pend[c]) m_drop[c] = 1;
                    else m_pend[c] = 1;
                end
                m_out[c] = (m_hi[c] > 0);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("coin_o", 32'(coin_o[c]), 32'(m_out[c]));
            chk("coin_drop_o", 32'(coin_drop_o[c]), 32'(m_drop[c]));
        end
        if (coin_o[0] === 1'b1) hi_cnt0++;
        if (coin_drop_o[0] === 1'b1) drop_cnt0++;
    endtask

    task automatic apply_vec();
        for (int c = 0; c < NUM_CH; c++) begin
            dir_i[4*c +: 4]    = vec[c][5:2];
            stickb_i[2*c +: 2] = vec[c][1:0];
        end
    endtask

    initial begin
        logic [1:0] new_mode;
        logic [7:0] e_before;
        logic [7:0] e_after;
        logic [3:0] pats [10];
        int         deb;

        // ---- reset with all inputs high
        Reset_n      = 1'b0;
        deb_cycles_i = 8'd2;
        coin_pulse_i = '1;
        coin_gap_i   = '1;
        mode_i       = '1;
        dir_i        = '1;
        stickb_i     = '1;
        coin_i       = '1;
        for (int c = 0; c < NUM_CH; c++) vec[c] = 6'h3f;
        repeat (3) tick();
        chk("reset_lever", 32'(lever_o), 32'(0));
        chk("reset_coin", 32'(coin_o), 32'(0));
        chk("reset_drop", 32'(coin_drop_o), 32'(0));
        Reset_n = 1'b1;
        repeat (4) tick();
        chk("release_lever", 32'(lever_o), 32'(exp_lever(vec[0], vec[1], mode_i)));
        coin_i = '0;
        coin_pulse_i = 16'd4;
        coin_gap_i   = 16'd3;
        mode_i = '0;
        for (int c = 0; c < NUM_CH; c++) vec[c] = 6'h00;
        apply_vec();
        repeat (6) tick();
        chk("settle_lever", 32'(lever_o), 32'(0));

        // ---- debounce latency and glitch rejection, deb=3
        deb_cycles_i = 8'd3;
        tick();
        vec[0] = 6'b1000_00;
        apply_vec();
        repeat (4) tick();
        chk("deb_edge4", 32'(lever_o[3:0]), 32'(4'b0000));
        tick();
        chk("deb_edge5", 32'(lever_o[3:0]), 32'(4'b1010));
        vec[0] = 6'b0000_00;
        apply_vec();
        repeat (2) tick();
        vec[0] = 6'b1000_00;
        apply_vec();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("deb_glitch", 32'(lever_o[3:0]), 32'(4'b1010));
        end

        // ---- translate sweep on ch1, bypass
        deb_cycles_i = 8'd0;
        pats = '{4'b1000, 4'b1010, 4'b1001, 4'b0001, 4'b0101,
                 4'b0100, 4'b0110, 4'b0010, 4'b1100, 4'b0011};
        for (int i = 0; i < 10; i++) begin
            vec[1] = {pats[i], 2'b00};
            apply_vec();
            repeat (2) tick();
            chk("sweep_ch1", 32'(lever_o[7:4]), 32'(f_lever(vec[1], 1'b0)));
        end
        chk("sweep_opp_ud", 32'(f_lever({4'b1100, 2'b00}, 1'b0)), 32'(0));
        chk("sweep_last", 32'(lever_o[7:4]), 32'(4'b0000));

        // ---- raw mode on ch0
        mode_i[0] = 1'b1;
        vec[0] = 6'b1000_01;
        apply_vec();
        repeat (2) tick();
        chk("raw_1001", 32'(lever_o[3:0]), 32'(4'b1001));
        mode_i[0] = 1'b0;
        tick();
        chk("mode_back_1edge", 32'(lever_o[3:0]), 32'(4'b1010));

        // ---- randomized lever/latency checks
        for (int it = 0; it < 40; it++) begin
            deb = $urandom_range(0, 4);
            deb_cycles_i = 8'(deb);
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                old_vec[c] = vec[c];
                if ($urandom_range(0, 1) == 1)
                    vec[c] = {TK[$urandom_range(0, 7)], 2'($urandom_range(0, 3))};
                else
                    vec[c] = 6'($urandom_range(0, 63));
            end
            new_mode = 2'($urandom_range(0, 3));
            mode_i   = new_mode;
            apply_vec();
            e_before = exp_lever(old_vec[0], old_vec[1], new_mode);
            e_after  = exp_lever(vec[0], vec[1], new_mode);
            repeat (deb + 1) tick();
            chk("rand_before", 32'(lever_o), 32'(e_before));
            tick();
            chk("rand_after", 32'(lever_o), 32'(e_after));
        end

        // ---- coin buffering: pulse=4, gap=3, rises 2 cycles apart
        coin_pulse_i = 16'd4;
        coin_gap_i   = 16'd3;
        coin_i = '0;
        repeat (20) tick();
        hi_cnt0   = 0;
        drop_cnt0 = 0;
        for (int k = 0; k < 3; k++) begin
            coin_i[0] = 1'b1;
            tick();
            coin_i[0] = 1'b0;
            tick();
        end
        repeat (20) tick();
        chk("coin_high_cycles", 32'(hi_cnt0), 32'(8));
        chk("coin_drop_count", 32'(drop_cnt0), 32'(1));

        // ---- reset mid-pulse, coin held high across reset
        coin_i[0] = 1'b1;
        tick();
        chk("pulse_start", 32'(coin_o[0]), 32'(1));
        tick();
        Reset_n = 1'b0;
        tick();
        chk("reset_abort", 32'(coin_o[0]), 32'(0));
        Reset_n = 1'b1;
        hi_cnt0 = 0;
        repeat (10) tick();
        chk("held_no_pulse", 32'(hi_cnt0), 32'(0));
        coin_i[0] = 1'b0;
        tick();
        coin_i[0] = 1'b1;
        tick();
        chk("new_edge_pulse", 32'(coin_o[0]), 32'(1));
        coin_i[0] = 1'b0;
        repeat (12) tick();

        // ---- randomized coin traffic with occasional reset
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 50 == 0) begin
                coin_pulse_i = 16'($urandom_range(0, 5));
                coin_gap_i   = 16'($urandom_range(0, 5));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 2) == 0) coin_i[c] = ~coin_i[c];
            end
            Reset_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        Reset_n = 1'b1;
        coin_i  = '0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tank_lever_mapper.md
Name: tank_lever_mapper

Overview:
- Parametrised, multi-channel successor to the fixed two-player joystick-to-tread translator in the arcade emu top.
- Per channel: debounces a 4-way stick (plus an optional second stick), then maps it to dual-tread levers (A = left tread, B = right tread, each with fw/bk).
- Per channel: a coin pulse shaper with a one-deep pending buffer.
- Sits between the input merge logic (keyboard/USB/DB9 OR) and the game core. The core-side inversion to active-low stays in the parent.

Parameters:
- NUM_CH, 2, number of player channels (1..4).
- DEB_W, 8, debounce counter width.
- COIN_W, 16, coin pulse/gap counter width.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- deb_cycles_i  in  DEB_W  stability cycles required; 0 = bypass.
- coin_pulse_i  in  COIN_W  coin output high time in cycles; 0 is treated as 1.
- coin_gap_i  in  COIN_W  low time after each pulse; 0 is treated as 1.
- mode_i  in  NUM_CH  per channel: 0 = 8-way translate, 1 = raw dual-stick.
- dir_i  in  4*NUM_CH  per channel {up,down,left,right}, active high.
- stickb_i  in  2*NUM_CH  per channel second stick {up,down}; used in raw mode only.
- coin_i  in  NUM_CH  coin request level, active high.
- lever_o  out  4*NUM_CH  per channel {A_fw,A_bk,B_fw,B_bk}, registered.
- coin_o  out  NUM_CH  shaped coin pulse, registered.
- coin_drop_o  out  NUM_CH  1-cycle strobe when a coin edge is discarded.

Behaviour:
- Reset (Reset_n=0 on a clock edge): lever_o=0, coin_o=0, coin_drop_o=0, all counters 0, FSMs IDLE, pending=0, stable registers=0, previous-coin registers=0.
- Reset mid-pulse aborts the pulse immediately on that edge.
- Debounce, per channel, on the 6-bit vector {dir,stickb}:
  - raw registered into samp.
  - If samp != stable, cnt increments; when cnt reaches deb_cycles_i, stable<=samp and cnt<=0.
  - If samp == stable, cnt<=0.
  - If samp changes while counting, cnt restarts at 0.
  - deb_cycles_i=0: stable<=samp every cycle.
- Latency: an input change held steady reaches lever_o after deb_cycles_i+2 edges (2 when bypassed).
- Decode: from stable and mode_i into lever_o on each edge. A mode_i change shows up on lever_o 1 edge later.
- Translate mode, {u,d,l,r} -> {A_fw,A_bk,B_fw,B_bk}:
  - 1000 -> 1010; 1010 -> 0010; 1001 -> 1000
  - 0001 -> 1001; 0101 -> 0100; 0100 -> 0101
  - 0110 -> 0001; 0010 -> 0110
  - any other combination, including none, opposing pairs or 3+ bits -> 0000.
- Raw mode:
  - A_fw=u&~d, A_bk=d&~u.
  - B_fw=stickb.up&~stickb.down, B_bk=stickb.down&~stickb.up.
  - left/right are ignored.
- Coin edge: rise = coin_i & ~coin_prev. Coin is not debounced.
- Coin FSM, per channel:
  - IDLE: on rise -> PULSE, ccnt<=max(coin_pulse_i,1)-1, coin_o<=1.
  - PULSE: ccnt>0 -> ccnt--; ccnt==0 -> GAP, ccnt<=max(coin_gap_i,1)-1, coin_o<=0.
  - GAP: ccnt>0 -> ccnt--; ccnt==0 -> PULSE (reload, coin_o<=1) if pending or rise this cycle, clearing pending; else IDLE.
  - rise in PULSE/GAP (not consumed as above): if pending=0, pending<=1; else coin_drop_o<=1 for one cycle.
- Coin timing: pulse high exactly max(coin_pulse_i,1) cycles; minimum low max(coin_gap_i,1) cycles. Counter values are sampled only at reload.
- Channels are fully independent; no shared state besides the timing inputs.

Test Plan:
- Reset: hold Reset_n=0 with all inputs high -> every output 0. Release -> lever_o follows within deb_cycles_i+2.
- Debounce: deb_cycles_i=3, ch0 dir=1000 steady -> lever_o[3:0]=1010 at edge 5. A glitch (dir=0000 for 2 cycles, then back) -> lever_o unchanged.
- Translate table sweep: deb=0, all 8 directions plus 1100 and 0011 on ch1 -> values per table; 1100 and 0011 give 0000, 2 edges after each apply.
- Raw mode: mode_i[0]=1, dir=1000, stickb=01 -> lever_o[3:0]=1001. Toggle mode_i[0] to 0 -> 1010 exactly 1 edge later.
- Coin buffering: pulse=4, gap=3; three coin rises 2 cycles apart -> coin_o high 4 cycles, low 3, high 4. The third rise gives coin_drop_o=1 for 1 cycle. No third pulse.
- Reset mid-pulse: Reset_n=0 during PULSE -> coin_o=0 on that edge, pending cleared. A coin_i held high after release gives no pulse until a new rising edge.
